flat_buffer_snapshot: RTL and testbench
=======================================

FLAT_BUFFER_SNAPSHOT -- requirements
Module: flat_buffer_snapshot

Interface
REQ-001 SHALL have parameter numChannels, default 16, number of parallel channels.
REQ-002 SHALL have parameter bitwidth, default 8, width of each signed sample.
REQ-003 SHALL have parameter depth, default 5; each channel presents depth+1 taps (0..depth).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port buffer  input  signed [bitwidth-1:0] x [numChannels-1:0][depth:0]  per-channel tap history from the upstream delay buffer; tap 0 is the newest sample.
REQ-007 SHALL have port arm  input  1  request to arm capture.
REQ-008 SHALL have port trigger  input  1  capture strobe.
REQ-009 SHALL have port out_data  output  signed [bitwidth-1:0]  current readout word.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port out_last  output  1  current word is the final word of the snapshot.
REQ-013 SHALL have port out_idx  output  clog2(N) bits  index k of the current word, where N = numChannels*(depth+1).
REQ-014 SHALL have port armed  output  1  FSM is in ARMED.
REQ-015 SHALL have port missed  output  8  saturating count of ignored triggers.

Function
REQ-016 SHALL implement FSM states IDLE, ARMED and DRAIN.
REQ-017 IDLE SHALL go to ARMED on a cycle with arm=1; trigger in the same cycle SHALL count as missed.
REQ-018 ARMED SHALL go to DRAIN on a cycle with trigger=1 and SHALL ignore arm.
REQ-019 On the ARMED-to-DRAIN edge, all N entries of buffer SHALL be registered into an internal snapshot and the word counter SHALL be set to 0.
REQ-020 Word k SHALL equal snapshot[c][d], with d = k / numChannels and c = k % numChannels (channel-fastest, newest tap first).
REQ-021 out_valid SHALL be 1 exactly when the FSM is in DRAIN; the first word SHALL be valid in the cycle after trigger is sampled.
REQ-022 A transfer SHALL occur on any cycle with out_valid & out_ready; on a transfer the counter SHALL increment by 1.
REQ-023 out_data, out_idx and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_last SHALL be 1 when the counter equals N-1 in DRAIN.
REQ-025 The transfer of word N-1 SHALL return the FSM to IDLE; out_valid SHALL be 0 in the next cycle.
REQ-026 Changes on buffer during DRAIN SHALL NOT affect the words read out.
REQ-027 trigger in IDLE or DRAIN SHALL increment missed, saturating at 255.
REQ-028 arm in ARMED or DRAIN SHALL have no effect.
REQ-029 Outside DRAIN, out_data SHALL be 0, out_idx SHALL be 0 and out_last SHALL be 0.
REQ-030 All arithmetic on samples SHALL be pass-through only, with no sign extension or truncation.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, counter=0, missed=0, snapshot=0, out_valid=0, out_last=0 and armed=0.
REQ-032 Reset SHALL take priority over arm, trigger and any handshake in the same cycle.
REQ-033 Reset during DRAIN SHALL abort the readout immediately, with no further valid words.

Verification
REQ-034 Bench SHALL cover: arm, then trigger with buffer[c][d] = 16*d + c and out_ready held at 1 -> 96 words k = 0..95 with data = k, out_last only at k = 95, and out_valid low after the final transfer.
REQ-035 Bench SHALL cover: out_ready toggling 1,0,0,1 throughout the readout -> no word dropped or duplicated, and data stable during stalls.
REQ-036 Bench SHALL cover: buffer changed to all -128 during DRAIN -> readout still equals the captured values.
REQ-037 Bench SHALL cover: 300 triggers applied in IDLE or DRAIN -> missed = 255.
REQ-038 Bench SHALL cover: rst asserted at word 40 -> next cycle out_valid = 0, armed = 0, missed = 0; a new arm/trigger sequence restarts at k = 0.
REQ-039 Bench SHALL cover: arm and trigger asserted together in IDLE -> ARMED with missed = 1, and no readout.

Source files
------------

// File: rtl/flat_buffer_snapshot.sv
// Arm/trigger snapshot of a multi-channel tap buffer, drained one word per
// accepted handshake in channel-fastest, newest-tap-first order.
module flat_buffer_snapshot #(
   parameter int unsigned numChannels = 16,
   parameter int unsigned bitwidth    = 8,
   parameter int unsigned depth       = 5
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic signed [bitwidth-1:0]                  buffer [numChannels-1:0][depth:0],
   input  logic                                        arm,
   input  logic                                        trigger,
   output logic signed [bitwidth-1:0]                  out_data,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic                                        out_last,
   output logic [$clog2(numChannels*(depth+1))-1:0]    out_idx,
   output logic                                        armed,
   output logic [7:0]                                  missed
);

   localparam int unsigned N     = numChannels * (depth + 1);
   localparam int unsigned IDX_W = $clog2(N);
   localparam int unsigned CH_W  = (numChannels > 1) ? $clog2(numChannels) : 1;
   localparam int unsigned TAP_W = (depth > 0) ? $clog2(depth + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                     state, state_nxt;
   logic [IDX_W-1:0]           count, count_nxt;
   logic [CH_W-1:0]            ch, ch_nxt;
   logic [TAP_W-1:0]           tap, tap_nxt;
   logic [7:0]                 missed_nxt;
   logic signed [bitwidth-1:0] snap     [numChannels-1:0][depth:0];
   logic signed [bitwidth-1:0] snap_nxt [numChannels-1:0][depth:0];
   logic signed [bitwidth-1:0] data_nxt;
   logic                       valid_nxt, last_nxt, armed_nxt;
   logic [IDX_W-1:0]           idx_nxt;

   // State register; all outputs are registered from their next-state values
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         count     <= '0;
         ch        <= '0;
         tap       <= '0;
         missed    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_idx   <= '0;
         armed     <= 1'b0;
         for (int c = 0; c < int'(numChannels); c++) begin
            for (int d = 0; d <= int'(depth); d++) begin
               snap[c][d] <= '0;
            end
         end
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         ch        <= ch_nxt;
         tap       <= tap_nxt;
         missed    <= missed_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         out_last  <= last_nxt;
         out_idx   <= idx_nxt;
         armed     <= armed_nxt;
         snap      <= snap_nxt;
      end
   end

   // Next-state, counters and next output values
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      ch_nxt     = ch;
      tap_nxt    = tap;
      snap_nxt   = snap;
      missed_nxt = missed;

      // Any trigger that does not cause a capture is counted as missed
      if (trigger && (state != S_ARMED) && (missed != 8'hFF)) begin
         missed_nxt = missed + 8'd1;
      end

      case (state)
         S_IDLE: begin
            if (arm) begin
               state_nxt = S_ARMED;
            end
         end
         S_ARMED: begin
            if (trigger) begin
               state_nxt = S_DRAIN;
               snap_nxt  = buffer;
               count_nxt = '0;
               ch_nxt    = '0;
               tap_nxt   = '0;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (count == IDX_W'(N - 1)) begin
                  state_nxt = S_IDLE;
                  count_nxt = '0;
                  ch_nxt    = '0;
                  tap_nxt   = '0;
               end else begin
                  count_nxt = count + IDX_W'(1);
                  if (ch == CH_W'(numChannels - 1)) begin
                     ch_nxt  = '0;
                     tap_nxt = tap + TAP_W'(1);
                  end else begin
                     ch_nxt = ch + CH_W'(1);
                  end
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      valid_nxt = (state_nxt == S_DRAIN);
      armed_nxt = (state_nxt == S_ARMED);
      data_nxt  = '0;
      idx_nxt   = '0;
      last_nxt  = 1'b0;
      if (valid_nxt) begin
         data_nxt = snap_nxt[ch_nxt][tap_nxt];
         idx_nxt  = count_nxt;
         last_nxt = (count_nxt == IDX_W'(N - 1));
      end
   end

endmodule

// File: tb/tb_flat_buffer_snapshot.sv
// Directed bench for flat_buffer_snapshot at default parameters (16 x 6 taps).
module tb_flat_buffer_snapshot;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [7:0] buffer [15:0][5:0];
   logic              arm, trigger, out_ready;
   logic signed [7:0] out_data;
   logic              out_valid, out_last, armed;
   logic [6:0]        out_idx;
   logic [7:0]        missed;

   int checks   = 0;
   int failures = 0;

   flat_buffer_snapshot #(.numChannels(16), .bitwidth(8), .depth(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .buffer    (buffer),
      .arm       (arm),
      .trigger   (trigger),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_idx   (out_idx),
      .armed     (armed),
      .missed    (missed)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load_pattern();
      for (int c = 0; c < 16; c++)
         for (int d = 0; d < 6; d++)
            buffer[c][d] = 8'(16 * d + c);
   endtask

   initial begin
      int k;
      int cyc;
      logic [3:0] rdy_pat;
      rdy_pat = 4'b1001;

      rst = 1'b1; arm = 1'b0; trigger = 1'b0; out_ready = 1'b0;
      load_pattern();
      step();
      step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_armed", 32'(armed), 32'd0);
      check("rst_missed", 32'(missed), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_data", 32'($unsigned(out_data)), 32'd0);
      rst = 1'b0;

      // arm and trigger together in IDLE: arms, counts one miss, no readout
      arm = 1'b1; trigger = 1'b1;
      step();
      arm = 1'b0; trigger = 1'b0;
      check("armtrig_armed", 32'(armed), 32'd1);
      check("armtrig_missed", 32'(missed), 32'd1);
      check("armtrig_valid", 32'(out_valid), 32'd0);
      step();
      check("armed_hold_valid", 32'(out_valid), 32'd0);
      check("armed_hold", 32'(armed), 32'd1);

      // full readout with out_ready held high
      trigger = 1'b1; out_ready = 1'b1;
      step();
      trigger = 1'b0;
      check("drain_armed", 32'(armed), 32'd0);
      for (k = 0; k < 96; k++) begin
         check("full_valid", 32'(out_valid), 32'd1);
         check("full_data", 32'($unsigned(out_data)), 32'(8'(k)));
         check("full_idx", 32'(out_idx), 32'(k));
         check("full_last", 32'(out_last), 32'(k == 95));
         step();
      end
      check("full_end_valid", 32'(out_valid), 32'd0);
      check("full_end_last", 32'(out_last), 32'd0);
      check("full_end_data", 32'($unsigned(out_data)), 32'd0);
      check("full_missed", 32'(missed), 32'd1);

      // stalled readout (ready 1,0,0,1) with buffer overwritten during DRAIN
      out_ready = 1'b0;
      arm = 1'b1;
      step();
      arm = 1'b0; trigger = 1'b1;
      step();
      trigger = 1'b0;
      for (int c = 0; c < 16; c++)
         for (int d = 0; d < 6; d++)
            buffer[c][d] = -8'sd128;
      k = 0;
      cyc = 0;
      while (k < 96 && cyc < 1000) begin
         out_ready = rdy_pat[3 - (cyc % 4)];
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'($unsigned(out_data)), 32'(8'(k)));
         check("stall_idx", 32'(out_idx), 32'(k));
         check("stall_last", 32'(out_last), 32'(k == 95));
         step();
         if (out_ready) k++;
         cyc++;
      end
      check("stall_words", 32'(k), 32'd96);
      check("stall_end_valid", 32'(out_valid), 32'd0);

      // reset in the middle of a readout at word 40
      load_pattern();
      out_ready = 1'b1;
      arm = 1'b1;
      step();
      arm = 1'b0; trigger = 1'b1;
      step();
      trigger = 1'b0;
      for (int i = 0; i < 40; i++) step();
      check("pre_rst_idx", 32'(out_idx), 32'd40);
      check("pre_rst_data", 32'($unsigned(out_data)), 32'd40);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_armed", 32'(armed), 32'd0);
      check("mid_rst_missed", 32'(missed), 32'd0);
      step();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      arm = 1'b1;
      step();
      arm = 1'b0; trigger = 1'b1;
      step();
      trigger = 1'b0;
      check("restart_valid", 32'(out_valid), 32'd1);
      check("restart_idx", 32'(out_idx), 32'd0);
      check("restart_data", 32'($unsigned(out_data)), 32'd0);
      step();
      check("restart_idx1", 32'(out_idx), 32'd1);

      // triggers during DRAIN count as missed
      trigger = 1'b1;
      step();
      step();
      trigger = 1'b0;
      check("drain_trig_missed", 32'(missed), 32'd2);
      check("drain_trig_idx", 32'(out_idx), 32'd3);
      for (int i = 0; i < 93; i++) step();
      check("restart_end_valid", 32'(out_valid), 32'd0);

      // 300 triggers in IDLE saturate the miss counter
      trigger = 1'b1;
      for (int i = 0; i < 252; i++) step();
      check("missed_254", 32'(missed), 32'd254);
      step();
      check("missed_255", 32'(missed), 32'd255);
      for (int i = 0; i < 47; i++) step();
      trigger = 1'b0;
      step();
      check("missed_sat", 32'(missed), 32'd255);
      check("missed_armed", 32'(armed), 32'd0);
      check("missed_valid", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
